// File: rtl/j2_io_peripherals.sv
// Memory-mapped I/O block for the j2 core: LED latch, buffered 8N1 UART
// transmitter, status register and free-running cycle counter.
module j2_io_peripherals #(
  parameter int WIDTH        = 16,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       io_address,
  input  logic             io_write_enable,
  input  logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] io_data_in,
  output logic [2:0]       leds,
  output logic             uart_tx
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    leds_q;
  logic [15:0]   cyc_q;
  logic          ovf_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;

  logic wr_led, push_req, ovf_clr, cyc_clr;
  logic fifo_empty, fifo_full, push, pop, tx_busy;
  logic unused_dout;

  assign wr_led   = io_write_enable && (io_address == 4'h0);
  assign push_req = io_write_enable && (io_address == 4'h1);
  assign ovf_clr  = io_write_enable && (io_address == 4'h2) && data_out[0];
  assign cyc_clr  = io_write_enable && (io_address == 4'h3);

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
  // A full FIFO still accepts a byte when the transmitter frees a slot on the same edge.
  assign push       = push_req && (!fifo_full || pop);
  assign tx_busy    = (state_q != S_IDLE);
  assign unused_dout = ^data_out[WIDTH-1:8];

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          timer_d = TMAX;
          state_d = S_START;
        end
      end
      S_START: begin
        if (timer_q == '0) begin
          timer_d = TMAX;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_DATA: begin
        if (timer_q == '0) begin
          timer_d = TMAX;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        // End of stop bit chains straight into the next start bit.
        if (timer_q == '0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            timer_d = TMAX;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= data_out[7:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      leds_q <= '0;
      cyc_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (ovf_clr)                             ovf_q <= 1'b0;
      else if (push_req && fifo_full && !pop)  ovf_q <= 1'b1;
      if (wr_led) leds_q <= data_out[2:0];
      cyc_q <= cyc_clr ? 16'h0000 : cyc_q + 16'h0001;
    end
  end

  always_comb begin
    io_data_in = '0;
    case (io_address)
      4'h0:    io_data_in[2:0]  = leds_q;
      4'h2:    io_data_in[3:0]  = {ovf_q, fifo_full, fifo_empty, tx_busy};
      4'h3:    io_data_in[15:0] = cyc_q;
      default: io_data_in = '0;
    endcase
  end

  // Combinational from registered state so reset forces the line high at once.
  always_comb begin
    case (state_q)
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = shift_q[0];
      default: uart_tx = 1'b1;
    endcase
  end

  assign leds = leds_q;

endmodule

// File: tb/tb_j2_io_peripherals.sv
// Scoreboard bench for j2_io_peripherals: register probes and decoded UART
// frames are checked by monitors against queued expectations.
module tb_j2_io_peripherals;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  io_address;
  logic        io_write_enable;
  logic [15:0] data_out;
  logic [15:0] io_data_in;
  logic [2:0]  leds;
  logic        uart_tx;

  j2_io_peripherals #(.WIDTH(16), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .io_address(io_address),
    .io_write_enable(io_write_enable), .data_out(data_out),
    .io_data_in(io_data_in), .leds(leds), .uart_tx(uart_tx)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    bit          sel_led;
    logic [15:0] exp;
  } exp_t;

  exp_t       rd_q[$];
  logic [7:0] uart_q[$];
  logic       probe = 1'b0;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Register probe monitor
  initial begin
    exp_t e;
    logic [15:0] act;
    forever begin
      @(negedge clock);
      if (probe) begin
        if (rd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL probe_underflow: got probe expected queued entry");
        end else begin
          e = rd_q.pop_front();
          act = e.sel_led ? {13'd0, leds} : io_data_in;
          checks++;
          if (act !== e.exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", e.name, act, e.exp);
          end
        end
      end
    end
  end

  // UART line monitor: samples mid-bit, drops frames cut by reset
  initial begin
    logic [7:0] b, e;
    logic start_ok, stop_b, abort;
    forever begin
      @(negedge clock);
      if (!reset && uart_tx === 1'b0) begin
        abort = 1'b0;
        repeat (2) @(negedge clock);
        abort |= reset;
        start_ok = (uart_tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clock);
          abort |= reset;
          b[i] = uart_tx;
        end
        repeat (4) @(negedge clock);
        abort |= reset;
        stop_b = uart_tx;
        if (!abort) begin
          checks++;
          if (uart_q.size() == 0) begin
            failures++;
            $display("FAIL uart_unexpected: got byte 0x%h expected none", b);
          end else begin
            e = uart_q.pop_front();
            if (b !== e || !start_ok || stop_b !== 1'b1) begin
              failures++;
              $display("FAIL uart_byte: got 0x%h start_ok=%0b stop=%0b expected 0x%h", b, start_ok, stop_b, e);
            end
          end
        end
      end
    end
  end

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    io_address = a; data_out = d; io_write_enable = 1'b1;
    @(posedge clock); #1;
    io_write_enable = 1'b0;
  endtask

  task automatic expect_rd(input string name, input logic [3:0] a, input logic [15:0] e);
    exp_t x;
    x.name = name; x.sel_led = 1'b0; x.exp = e;
    io_address = a;
    rd_q.push_back(x);
    probe = 1'b1;
    @(posedge clock); #1;
    probe = 1'b0;
  endtask

  task automatic expect_led(input string name, input logic [2:0] e);
    exp_t x;
    x.name = name; x.sel_led = 1'b1; x.exp = {13'd0, e};
    rd_q.push_back(x);
    probe = 1'b1;
    @(posedge clock); #1;
    probe = 1'b0;
  endtask

  // Counts cycles with STATUS.tx_busy set until it drops; optionally checks line bits.
  task automatic busy_run(input int bound, input bit chk_pat, input logic [9:0] pat, output int n);
    bit done;
    n = 0; done = 1'b0;
    io_address = 4'h2;
    for (int k = 0; k < bound && !done; k++) begin
      @(negedge clock);
      if (io_data_in[0]) begin
        if (chk_pat && (n % 4 == 2) && (n / 4) < 10)
          chk($sformatf("line_bit%0d", n / 4), {15'd0, uart_tx}, {15'd0, pat[n / 4]});
        n++;
      end else if (n > 0) begin
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL busy_timeout: got busy run %0d unfinished expected completion", n);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    int n;
    reset = 1'b1; io_address = 4'h0; io_write_enable = 1'b0; data_out = 16'h0;
    repeat (2) @(posedge clock); #1;

    // 1: reset state, LED latch, unmapped writes
    expect_rd("rst_status", 4'h2, 16'h0002);
    expect_led("rst_leds", 3'b000);
    chk("rst_uart_tx", {15'd0, uart_tx}, 16'h0001);
    reset = 1'b0;
    wr(4'h0, 16'h0005);
    expect_led("leds_101", 3'b101);
    expect_rd("rd_led", 4'h0, 16'h0005);
    wr(4'h7, 16'h0002);
    expect_rd("unmapped_wr_ignored", 4'h0, 16'h0005);
    expect_rd("rd_txdata_zero", 4'h1, 16'h0000);
    expect_rd("rd_unmapped_zero", 4'hA, 16'h0000);

    // 2: single frame 0x55, exact busy length and line pattern
    uart_q.push_back(8'h55);
    wr(4'h1, 16'h0055);
    busy_run(100, 1'b1, 10'h2AA, n);
    chk("busy_len_single", 16'(n), 16'd40);

    // 3: six consecutive pushes, sixth dropped, back-to-back frames
    for (int i = 0; i < 5; i++) uart_q.push_back(8'h41 + 8'(i));
    for (int i = 0; i < 6; i++) wr(4'h1, 16'hFF41 + 16'(i));
    expect_rd("status_ovf_full", 4'h2, 16'h000D);
    wr(4'h2, 16'h0001);
    expect_rd("status_ovf_cleared", 4'h2, 16'h0005);
    busy_run(400, 1'b0, 10'h0, n);
    chk("busy_len_burst", 16'(n), 16'd193);
    expect_rd("status_drained", 4'h2, 16'h0002);

    // 4: push on the exact pop edge while full
    for (int i = 0; i < 6; i++) uart_q.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 5; i++) wr(4'h1, 16'h0010 + 16'(i));
    expect_rd("status_full", 4'h2, 16'h0005);
    repeat (35) @(posedge clock); #1;
    wr(4'h1, 16'h0015);
    expect_rd("status_push_on_pop", 4'h2, 16'h0005);
    busy_run(400, 1'b0, 10'h0, n);
    expect_rd("status_drained2", 4'h2, 16'h0002);

    // 5: reset during a data bit of 0xA3
    wr(4'h1, 16'h00A3);
    wr(4'h0, 16'h0007);
    expect_led("leds_111", 3'b111);
    repeat (12) @(posedge clock); #1;
    chk("tx_data_bit2", {15'd0, uart_tx}, 16'h0000);
    reset = 1'b1;
    #1;
    chk("tx_high_on_reset", {15'd0, uart_tx}, 16'h0001);
    expect_rd("status_after_reset", 4'h2, 16'h0002);
    expect_led("leds_after_reset", 3'b000);
    repeat (3) @(posedge clock); #1;
    reset = 1'b0;
    expect_rd("status_post_release", 4'h2, 16'h0002);

    // 6: cycle counter clear and wrap
    wr(4'h3, 16'hFFFE);
    @(posedge clock); #1;
    expect_rd("cycles_one", 4'h3, 16'h0001);
    repeat (65533) @(posedge clock); #1;
    expect_rd("cycles_ffff", 4'h3, 16'hFFFF);
    expect_rd("cycles_wrap", 4'h3, 16'h0000);

    repeat (4) @(posedge clock); #1;
    chk("probe_queue_empty", 16'(rd_q.size()), 16'd0);
    chk("uart_queue_empty", 16'(uart_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
